// File: rtl/move_argmax_layer_pkg.sv
// move_argmax_layer_pkg
//   Shared definitions for the move argmax stage:
//   - DATA_LEN : system-wide signed element width (same value used by the
//                upstream layers; do not redefine it locally)
//   - NUM_DEF  : default number of moves per score vector
//   - IDX_W    : width of the returned move index (fixed at 4, NUM <= 16)
//   - CNT_W    : scan counter width, one bit wider so it can reach NUM
//   - state_e  : controller states AIDLE / ASCAN / ADONE
package move_argmax_layer_pkg;

  localparam int DATA_LEN = 8;
  localparam int NUM_DEF  = 12;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = IDX_W + 1;

  typedef enum logic [1:0] {
    AIDLE = 2'd0,
    ASCAN = 2'd1,
    ADONE = 2'd2
  } state_e;

endpackage

// File: rtl/move_argmax_layer_score_sub.sv
// move_argmax_layer_score_sub
//   Combinational signed subtract s = a - b, widened by one bit so that the
//   full range (max positive minus max negative) is represented exactly.
// Ports:
//   a_i  in  DATA_LEN    signed minuend
//   b_i  in  DATA_LEN    signed subtrahend
//   s_o  out DATA_LEN+1  signed difference
module move_argmax_layer_score_sub
  import move_argmax_layer_pkg::*;
#(
  parameter int W = DATA_LEN
) (
  input  logic signed [W-1:0] a_i,
  input  logic signed [W-1:0] b_i,
  output logic signed [W:0]   s_o
);

  // Sign-extend both operands by one bit, then subtract.
  assign s_o = $signed({a_i[W-1], a_i}) - $signed({b_i[W-1], b_i});

endmodule

// File: rtl/move_argmax_layer.sv
// move_argmax_layer
//   Final decision stage: scans s[i] = d1[i] - d2[i] serially (one element per
//   clock, a single subtractor/comparator) and returns the index of the
//   maximum. Ties resolve to the lowest index.
//   Timing: capture edge T, evaluations on edges T+1..T+NUM, valid on T+NUM+1.
// Ports:
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   load       in   1            level request, held high for the whole operation
//   d1         in   NUM*DATA_LEN packed signed scores, element i at [i*DATA_LEN +: DATA_LEN]
//   d2         in   NUM*DATA_LEN same packing as d1
//   valid      out  1            result ready (DONE state)
//   q          out  4            argmax index
//   best_score out  DATA_LEN+1   winning score, only when ARGMAX_SCORE_OUT_EN is defined
// Configuration macro: ARGMAX_SCORE_OUT_EN
module move_argmax_layer
  import move_argmax_layer_pkg::*;
#(
  parameter int W   = DATA_LEN,
  parameter int NUM = NUM_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [NUM*W-1:0]     d1,
  input  logic [NUM*W-1:0]     d2,
  output logic                 valid,
  output logic [IDX_W-1:0]     q
`ifdef ARGMAX_SCORE_OUT_EN
  ,
  output logic signed [W:0]    best_score
`endif
);

  state_e                  state_q;
  logic [NUM*W-1:0]        d1_q, d2_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [W:0]       best_q;
  logic [IDX_W-1:0]        best_idx_q;
  logic                    valid_q;
  logic [IDX_W-1:0]        q_q;
  logic signed [W:0]       score_q;

  logic signed [W-1:0]     a_d, b_d;
  logic signed [W:0]       score_d;
  logic signed [W:0]       best_d;
  logic [IDX_W-1:0]        best_idx_d;

  // Select the pair addressed by the scan counter (zero once the counter passes NUM-1).
  always_comb begin
    a_d = '0;
    b_d = '0;
    for (int i = 0; i < NUM; i++) begin
      a_d = a_d | ((cnt_q == CNT_W'(i)) ? d1_q[i*W +: W] : {W{1'b0}});
      b_d = b_d | ((cnt_q == CNT_W'(i)) ? d2_q[i*W +: W] : {W{1'b0}});
    end
  end

  move_argmax_layer_score_sub #(.W(W)) u_score_sub (
    .a_i (a_d),
    .b_i (b_d),
    .s_o (score_d)
  );

  // Running maximum: element 0 always seeds, later elements win only if strictly greater.
  always_comb begin
    best_d     = best_q;
    best_idx_d = best_idx_q;
    if ((cnt_q == {CNT_W{1'b0}}) || (score_d > best_q)) begin
      best_d     = score_d;
      best_idx_d = cnt_q[IDX_W-1:0];
    end else begin
      best_d     = best_q;
      best_idx_d = best_idx_q;
    end
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= AIDLE;
      d1_q       <= '0;
      d2_q       <= '0;
      cnt_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      valid_q    <= 1'b0;
      q_q        <= '0;
      score_q    <= '0;
    end else begin
      case (state_q)
        AIDLE: begin
          if (load) begin
            d1_q    <= d1;
            d2_q    <= d2;
            cnt_q   <= '0;
            state_q <= ASCAN;
          end
        end
        ASCAN: begin
          if (!load) begin
            // Abort: no result, q keeps the previous answer.
            state_q <= AIDLE;
          end else if (cnt_q == CNT_W'(NUM)) begin
            state_q <= ADONE;
            valid_q <= 1'b1;
            q_q     <= best_idx_q;
            score_q <= best_q;
          end else begin
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            cnt_q      <= cnt_q + CNT_W'(1);
          end
        end
        ADONE: begin
          if (!load) begin
            state_q <= AIDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= AIDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid = valid_q;
  assign q     = q_q;
`ifdef ARGMAX_SCORE_OUT_EN
  assign best_score = score_q;
`else
  // Winning score is kept internally only in this build.
  logic unused_score_s;
  assign unused_score_s = ^score_q;
`endif

endmodule
